// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the access legality check used when a request is accepted.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_state_e;

  // Misaligned, reserved-size and beyond-the-array accesses are reported, never performed.
  function automatic logic access_error(input logic [31:0] addr,
                                        input mem_size_e   size,
                                        input int unsigned depth_words);
    logic misaligned;
    misaligned = ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    return (size == SZ_RSVD) || misaligned || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for
// writes, addressed-lane extraction with sign/zero extension for loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rword[8*addr_lo +: 8];
  assign sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    lane_wdata = 32'h0;
    load_data  = 32'h0;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = is_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = is_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        lane_wdata = wdata;
        load_data  = rword;
      end
      default: begin
        byte_en    = 4'b0000;
        lane_wdata = 32'h0;
        load_data  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with a programmable number of wait states between
// request acceptance and the memory access; one transaction in flight at a time.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_state_e    state;
  logic [3:0]    cnt;
  logic          write_q;
  logic [AW+1:0] addr_q;
  mem_size_e     size_q;
  logic          unsigned_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   rword;
  logic [3:0]    byte_en;
  logic [31:0]   lane_wdata;
  logic [31:0]   load_data;
  logic          access_now;
  logic          commit;

  assign req_ready  = rst && (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign word_idx   = addr_q[AW+1:2];
  assign rword      = mem[word_idx];
  assign access_now = (state == ST_WAIT) && (cnt == 4'd0);
  assign commit     = rst && access_now && write_q && !err_q;

  mem_lane_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .rword       (rword),
    .byte_en     (byte_en),
    .lane_wdata  (lane_wdata),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            write_q    <= req_write;
            addr_q     <= req_addr[AW+1:0];
            size_q     <= mem_size_e'(req_size);
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            err_q      <= access_error(req_addr, mem_size_e'(req_size), DEPTH_WORDS);
            cnt        <= 4'(WAIT_CYCLES);
            state      <= ST_WAIT;
          end
        end
        // With zero wait states the counter is already 0 here, so the access follows the handshake directly.
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_error <= err_q;
            rsp_rdata <= (err_q || write_q) ? 32'h0 : load_data;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'h0;
            rsp_error <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The array itself is never reset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: a driver pushes expected responses computed from a byte-level
// reference memory, and an independent monitor pops and compares them.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs_cycle;
  } exp_t;

  exp_t       exp_q[$];
  bit         bp_mode = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] ref_mem [4*DEPTH];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference behaviour: byte-addressed memory, little-endian assembly, arithmetic sign extension.
  function automatic void model_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                    input logic uns, input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic err);
    int n;
    longint v;
    rdata = 32'h0;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(4*DEPTH));
    if (err) return;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++) begin
      if (wr) ref_mem[int'(addr) + i] = 8'(wdata >> (8*i));
      else    v = v + longint'(ref_mem[int'(addr) + i]) * (longint'(1) << (8*i));
    end
    if (!wr) begin
      if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
      rdata = 32'(v);
    end
  endfunction

  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata);
    exp_t e;
    int waited = 0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check_output("req_accept_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    model_req(wr, addr, size, uns, wdata, e.rdata, e.err);
    e.hs_cycle = cycle + 1;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((exp_q.size() != 0 || rsp_valid) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      check_output("drain_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_valid;
    logic was_accept;
    logic [31:0] held_data;
    logic held_err;
    int stall_left;
    prev_valid = 1'b0;
    was_accept = 1'b0;
    held_data  = 32'h0;
    held_err   = 1'b0;
    stall_left = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
        was_accept = 1'b0;
        stall_left = 0;
        continue;
      end
      if (was_accept) begin
        check_output("idle_req_ready", 32'(req_ready), 32'h1);
        check_output("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("idle_rsp_rdata", rsp_rdata, 32'h0);
        check_output("idle_rsp_error", 32'(rsp_error), 32'h0);
        was_accept = 1'b0;
      end
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) check_output("unexpected_rsp", 32'(rsp_valid), 32'h0);
        else check_output("rsp_latency", 32'(cycle), 32'(exp_q[0].hs_cycle + WAITS + 1));
        if (bp_mode) stall_left = 5;
        held_data = rsp_rdata;
        held_err  = rsp_error;
      end else if (rsp_valid) begin
        check_output("hold_rdata", rsp_rdata, held_data);
        check_output("hold_error", 32'(rsp_error), 32'(held_err));
      end
      if (rsp_valid) check_output("req_ready_in_resp", 32'(req_ready), 32'h0);
      if (stall_left > 0) begin
        rsp_ready = 1'b0;
        stall_left--;
      end else if (bp_mode) begin
        rsp_ready = 1'b1;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("rsp_rdata", rsp_rdata, e.rdata);
        check_output("rsp_error", 32'(rsp_error), 32'(e.err));
        was_accept = 1'b1;
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int waited;
    logic [31:0] a;
    logic [1:0]  sz;
    int r;

    #2 rst = 1'b0;
    #1;
    check_output("reset_req_ready", 32'(req_ready), 32'h0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("reset_rsp_rdata", rsp_rdata, 32'h0);
    check_output("reset_rsp_error", 32'(rsp_error), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check_output("release_req_ready", 32'(req_ready), 32'h1);

    apply_stimulus(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    apply_stimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    apply_stimulus(1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080);
    apply_stimulus(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
    apply_stimulus(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
    apply_stimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    apply_stimulus(1'b1, 32'h22, 2'd1, 1'b0, 32'h00001234);
    apply_stimulus(1'b0, 32'h22, 2'd1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 32'h21, 2'd1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 32'h21, 2'd1, 1'b0, 32'h0000FFFF);
    apply_stimulus(1'b0, 32'h22, 2'd1, 1'b1, 32'h0);
    apply_stimulus(1'b1, 32'h400, 2'd2, 1'b0, 32'hCAFEF00D);
    apply_stimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    apply_stimulus(1'b0, 32'h12, 2'd3, 1'b0, 32'h0);
    wait_drain();

    // Backpressure: response must hold for five stalled cycles.
    bp_mode = 1'b1;
    apply_stimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    wait_drain();
    repeat (2) @(negedge clk);
    bp_mode = 1'b0;

    // Reset during the wait states of a byte store must drop the store.
    apply_stimulus(1'b1, 32'h04, 2'd2, 1'b0, 32'hA5A5A5A5);
    wait_drain();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h04;
    req_size  = 2'd0;
    req_wdata = 32'h00000055;
    waited = 0;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_output("reset_test_accept", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_output("midrst_req_ready", 32'(req_ready), 32'h0);
    check_output("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("midrst_rsp_rdata", rsp_rdata, 32'h0);
    check_output("midrst_rsp_error", 32'(rsp_error), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check_output("midrst_release_ready", 32'(req_ready), 32'h1);
    apply_stimulus(1'b0, 32'h04, 2'd2, 1'b0, 32'h0);
    wait_drain();

    // Make words 0..15 known, then mix random legal and illegal accesses.
    for (int w = 0; w < 16; w++) apply_stimulus(1'b1, 32'(4*w), 2'd2, 1'b0, $urandom);
    for (int k = 0; k < 80; k++) begin
      r  = $urandom_range(0, 7);
      sz = (r == 7) ? 2'd3 : 2'(r % 3);
      if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 1023));
      else a = 32'($urandom_range(0, 63));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      apply_stimulus(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
